// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronizes the serial line, finds frame start and
// sample points, and steers an external 9-bit right-shift SIPO that collects data+parity.
module uart_rx_ctrl #(
  parameter int unsigned ClksPerBit = 868,
  parameter bit          ParityOdd  = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  input  logic [8:0] frame_i,
  output logic       sdata_o,
  output logic [1:0] op_o,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam logic [15:0] HALF_TC  = 16'(ClksPerBit / 2 - 1);
  localparam logic [15:0] BIT_TC   = 16'(ClksPerBit - 1);
  localparam logic [1:0]  OP_CLEAR = 2'b00;
  localparam logic [1:0]  OP_HOLD  = 2'b01;
  localparam logic [1:0]  OP_SHIFT = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BITS  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_r, state_n;
  logic [15:0] baud_r, baud_n;
  logic [3:0]  bit_r, bit_n;
  logic        stop_err_r, stop_err_n;
  logic        sync1_r, sync2_r, prev_r;
  logic [1:0]  op_s;

  // Parity check result over data+parity: 1 means mismatch.
  function automatic logic parity_error(input logic [8:0] f, input logic odd);
    return (^f) ^ odd;
  endfunction

  // Two-flop synchronizer plus one extra stage for falling-edge detection.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rx_i;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign sdata_o = sync2_r;

  // Next-state, counter and SIPO command logic.
  always_comb begin
    state_n    = state_r;
    baud_n     = baud_r;
    bit_n      = bit_r;
    stop_err_n = stop_err_r;
    op_s       = OP_HOLD;
    case (state_r)
      IDLE: begin
        if (prev_r && !sync2_r) begin
          state_n = START;
          baud_n  = 16'd0;
          op_s    = OP_CLEAR;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (baud_r == HALF_TC) begin
          baud_n = 16'd0;
          bit_n  = 4'd0;
          // A line already back high at mid-start is a glitch, not a frame.
          if (!sync2_r) begin
            state_n = BITS;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_r + 16'd1;
        end
      end
      BITS: begin
        if (baud_r == BIT_TC) begin
          op_s   = OP_SHIFT;
          baud_n = 16'd0;
          if (bit_r == 4'd8) begin
            state_n = STOP;
            bit_n   = 4'd0;
          end else begin
            bit_n = bit_r + 4'd1;
          end
        end else begin
          baud_n = baud_r + 16'd1;
        end
      end
      STOP: begin
        if (baud_r == BIT_TC) begin
          stop_err_n = ~sync2_r;
          baud_n     = 16'd0;
          state_n    = DONE;
        end else begin
          baud_n = baud_r + 16'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        baud_n  = 16'd0;
        bit_n   = 4'd0;
      end
    endcase
  end

  // Reset forces a SIPO clear without waiting for a clock edge.
  assign op_o   = rst_ni ? op_s : OP_CLEAR;
  assign busy_o = (state_r != IDLE);

  // FSM state and counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      baud_r     <= 16'd0;
      bit_r      <= 4'd0;
      stop_err_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      baud_r     <= baud_n;
      bit_r      <= bit_n;
      stop_err_r <= stop_err_n;
    end
  end

  // Result registers: updated once per accepted frame, held otherwise.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_o       <= 8'd0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      valid_o <= (state_r == DONE);
      if (state_r == DONE) begin
        data_o       <= frame_i[7:0];
        parity_err_o <= parity_error(frame_i, ParityOdd);
        frame_err_o  <= stop_err_r;
      end else begin
        data_o       <= data_o;
        parity_err_o <= parity_err_o;
        frame_err_o  <= frame_err_o;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl with a behavioural 9-bit SIPO on frame_i.
module tb_uart_rx_ctrl;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [8:0] frame = 9'd0;
  logic       sdata;
  logic [1:0] op;
  logic [7:0] data;
  logic       valid, perr, ferr, busy;

  int compared   = 0;
  int mismatched = 0;
  int shifts     = 0;
  logic prev_valid = 1'b0;
  logic [9:0] exp_q[$];

  uart_rx_ctrl #(.ClksPerBit(CPB), .ParityOdd(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .frame_i(frame),
    .sdata_o(sdata), .op_o(op), .data_o(data), .valid_o(valid),
    .parity_err_o(perr), .frame_err_o(ferr), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Downstream SIPO: new bit enters the MSB, register shifts right.
  always @(posedge clk) begin
    case (op)
      2'b00:   frame <= 9'd0;
      2'b10:   frame <= {sdata, frame[8:1]};
      default: frame <= frame;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: counts shift commands and checks each result against the scoreboard.
  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst_n) shifts = 0;
    else if (op == 2'b10) shifts++;
    if (valid) begin
      chk("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {24'd0, data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("data", {24'd0, data}, {24'd0, e[9:2]});
        chk("parity_err", {31'd0, perr}, {31'd0, e[1]});
        chk("frame_err", {31'd0, ferr}, {31'd0, e[0]});
        chk("shift_count", shifts, 32'd9);
      end
      shifts = 0;
    end
    prev_valid = valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first, parity and stop; optional reset mid data bit 3.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                            input bit expect_it, input logic pe, input logic fe,
                            input bit rst_mid);
    logic [10:0] bits;
    bits = {stop, p, d, 1'b0};
    if (expect_it) exp_q.push_back({d, pe, fe});
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      if (rst_mid && i == 4) begin
        tick(CPB / 2);
        rst_n = 1'b0;
        #2;
        chk("op_clear_in_reset", {30'd0, op}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        chk("busy_after_reset", {31'd0, busy}, 32'd0);
        chk("valid_after_reset", {31'd0, valid}, 32'd0);
        tick(CPB / 2 - 1);
      end else begin
        tick(CPB);
      end
    end
  endtask

  initial begin
    int busy_cnt;
    tick(3);
    chk("reset_op", {30'd0, op}, 32'd0);
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_perr", {31'd0, perr}, 32'd0);
    chk("reset_ferr", {31'd0, ferr}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_sdata", {31'd0, sdata}, 32'd1);
    rst_n = 1'b1;
    tick(1);
    chk("idle_op_hold", {30'd0, op}, 32'd1);
    tick(4);

    // 0xA5 clean, then 0x3C with a wrong parity bit.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2 * CPB);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(2 * CPB);

    // Break: stop bit low and line held low for 40 bit times.
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    rx = 1'b0;
    tick(40 * CPB);
    rx = 1'b1;
    tick(2 * CPB);

    // Short low glitch must be rejected at mid-start.
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 3 * CPB; i++) begin
      tick(1);
      if (busy) busy_cnt++;
    end
    chk("glitch_busy_seen", {31'd0, busy_cnt != 0}, 32'd1);
    chk("glitch_busy_short", {31'd0, busy_cnt < 9}, 32'd1);
    chk("glitch_no_shift", shifts, 32'd0);

    // Reset inside data bit 3 abandons the frame; next frame is clean.
    send_frame(8'hF8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(2 * CPB);
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2 * CPB);

    // Back-to-back frames with a single stop bit.
    send_frame(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3 * CPB);

    chk("all_frames_seen", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    compared++;
    mismatched++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
